// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter and read scheduler in front of an 8-bit x16 synchronous FIFO.
// Optional per-producer accepted-beat statistics are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     cons_rd,
  output logic                     cons_ack,
  output logic                     cons_dv,
  output logic                     fifo_wr,
  output logic [DW-1:0]            fifo_din,
  output logic                     fifo_rd,
  input  logic                     fifo_full,
  input  logic                     fifo_empty,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  input  logic [$clog2(NREQ)-1:0]  stat_sel,
  output logic [15:0]              stat_cnt
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]    state, state_n;
  logic [IW-1:0] rr_ptr, rr_ptr_n;
  logic [IW-1:0] grant_n;
  logic [BW-1:0] beat_cnt, beat_cnt_n;

  logic          rd_win;
  logic          accept;
  logic          win_found;
  logic [IW-1:0] win_id;
  logic [IW-1:0] idx;
  logic [IW-1:0] next_ptr;

  // Next-state, arbitration and combinational FIFO-side outputs
  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    grant_n    = grant_id;
    beat_cnt_n = beat_cnt;
    req_ready  = '0;
    fifo_wr    = 1'b0;
    fifo_din   = '0;
    accept     = 1'b0;
    win_found  = 1'b0;
    win_id     = '0;
    idx        = '0;

    rd_win   = cons_rd & ~fifo_empty;
    next_ptr = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);

    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IW'((32'(rr_ptr) + k) % NREQ);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end

    case (state)
      ST_IDLE: begin
        if (win_found) begin
          grant_n    = win_id;
          beat_cnt_n = '0;
          state_n    = ST_BURST;
        end
      end
      default: begin
        // A consumer read owns the FIFO this cycle, so the write must wait
        req_ready[grant_id] = ~fifo_full & ~rd_win;
        accept   = req_valid[grant_id] & req_ready[grant_id];
        fifo_wr  = accept;
        fifo_din = req_data[32'(grant_id)*DW +: DW];
        if (!req_valid[grant_id]) begin
          rr_ptr_n = next_ptr;
          state_n  = ST_IDLE;
        end else if (accept) begin
          beat_cnt_n = beat_cnt + BW'(1);
          if (req_last[grant_id] || (beat_cnt == BW'(MAX_BURST - 1))) begin
            rr_ptr_n = next_ptr;
            state_n  = ST_IDLE;
          end
        end
      end
    endcase

    fifo_rd  = cons_rd;
    cons_ack = rd_win;

    if (rst) begin
      req_ready = '0;
      fifo_wr   = 1'b0;
      fifo_din  = '0;
      fifo_rd   = 1'b0;
      cons_ack  = 1'b0;
      accept    = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
      cons_dv  <= 1'b0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      grant_id <= grant_n;
      beat_cnt <= beat_cnt_n;
      busy     <= (state_n == ST_BURST);
      cons_dv  <= cons_ack;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] beat_tot [NREQ];

  // Saturating accepted-beat counters with a registered read-out mux
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) beat_tot[i] <= '0;
      stat_cnt <= '0;
    end else begin
      if (accept && (beat_tot[grant_id] != 16'hFFFF))
        beat_tot[grant_id] <= beat_tot[grant_id] + 16'd1;
      stat_cnt <= (32'(stat_sel) < NREQ) ? beat_tot[stat_sel] : 16'h0000;
    end
  end
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_cnt        = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a small behavioural FIFO model on the FIFO side.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IW   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_last;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]  req_ready;
  logic             cons_rd, cons_ack, cons_dv;
  logic             fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [DW-1:0]    fifo_din;
  logic [IW-1:0]    grant_id, stat_sel;
  logic             busy;
  logic [15:0]      stat_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(4), .DW(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .cons_rd(cons_rd), .cons_ack(cons_ack), .cons_dv(cons_dv),
    .fifo_wr(fifo_wr), .fifo_din(fifo_din), .fifo_rd(fifo_rd),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .grant_id(grant_id), .busy(busy), .stat_sel(stat_sel), .stat_cnt(stat_cnt)
  );

  // FIFO model: 16 deep, write has precedence over read, plus full/empty overrides
  logic       force_full, force_empty;
  logic [7:0] fq[$];
  logic [7:0] wlog[$];
  logic [7:0] dout_m;
  int         fcnt;

  assign fifo_full  = force_full | (fcnt >= 16);
  assign fifo_empty = force_empty | (fcnt == 0);

  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      wlog.delete();
      fcnt   <= 0;
      dout_m <= 8'h00;
    end else if (fifo_wr && !fifo_full) begin
      fq.push_back(fifo_din);
      wlog.push_back(fifo_din);
      fcnt <= fcnt + 1;
    end else if (fifo_rd && !fifo_empty) begin
      dout_m <= fq.pop_front();
      fcnt   <= fcnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int       nxt;
  int       stall;
  int       stalls_seen;
  logic     ok;

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
    cons_rd = 1'b0; stat_sel = '0; force_full = 1'b0; force_empty = 1'b0;
    tick(); tick();

    // Reset: registered state and forced-low combinational outputs
    req_valid = 4'b1111; cons_rd = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_dv", cons_dv, 0);
    chk("rst_stat", stat_cnt, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_wr", fifo_wr, 0);
    chk("rst_rd", fifo_rd, 0);
    chk("rst_ack", cons_ack, 0);
    req_valid = '0; cons_rd = 1'b0;
    tick();
    rst = 1'b0;

    // Single burst from producer 1
    req_valid = 4'b0010; req_data[8 +: 8] = 8'hA1;
    #1;
    chk("t1_idle_wr", fifo_wr, 0);
    chk("t1_idle_ready", req_ready, 0);
    tick();
    #1;
    chk("t1_busy", busy, 1);
    chk("t1_grant", grant_id, 1);
    chk("t1_ready", req_ready, 4'b0010);
    chk("t1_wr1", fifo_wr, 1);
    chk("t1_din1", fifo_din, 8'hA1);
    tick();
    req_data[8 +: 8] = 8'hA2;
    #1;
    chk("t1_wr2", fifo_wr, 1);
    chk("t1_din2", fifo_din, 8'hA2);
    tick();
    req_data[8 +: 8] = 8'hA3; req_last = 4'b0010;
    #1;
    chk("t1_wr3", fifo_wr, 1);
    chk("t1_din3", fifo_din, 8'hA3);
    tick();
    req_valid = 4'b0111; req_last = '0;
    #1;
    chk("t1_busy_end", busy, 0);
    chk("t1_grant_hold", grant_id, 1);
    chk("t1_n", wlog.size(), 3);
    chk("t1_q0", wlog[0], 8'hA1);
    chk("t1_q1", wlog[1], 8'hA2);
    chk("t1_q2", wlog[2], 8'hA3);
    tick();
    req_valid = '0;
    #1;
    chk("t1_rrptr", grant_id, 2);
    chk("t1_drop_wr", fifo_wr, 0);
    tick();
    chk("t1_drop_busy", busy, 0);

    // 4-way contention, continuous valid, bursts capped at 4 beats
    do_reset();
    req_valid = 4'b1111; req_last = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*8 +: 8] = 8'(8'hB0 + i);
    for (int k = 0; k < 20; k++) begin
      #1;
      chk($sformatf("t2_wr_%0d", k), fifo_wr, (k % 5) != 0);
      if ((k % 5) != 0) begin
        chk($sformatf("t2_din_%0d", k), fifo_din, 8'hB0 + k / 5);
        chk($sformatf("t2_grant_%0d", k), grant_id, k / 5);
      end
      tick();
    end
    #1;
    chk("t2_idle_wr", fifo_wr, 0);
    chk("t2_fill", wlog.size(), 16);
    tick();
    #1;
    chk("t2_wrap_grant", grant_id, 0);
    chk("t2_wrap_busy", busy, 1);
    chk("t2_full_ready", req_ready, 0);
    chk("t2_full_wr", fifo_wr, 0);

    // Per-producer beat totals
    for (int i = 0; i < NREQ; i++) begin
      stat_sel = IW'(i);
      tick();
`ifdef FIFO_ARB_STATS_EN
      chk($sformatf("stat_%0d", i), stat_cnt, 4);
`else
      chk($sformatf("stat_%0d", i), stat_cnt, 0);
`endif
    end

    // Full stall mid-burst from producer 3
    req_valid = '0;
    do_reset();
    req_valid = 4'b1000; stall = 5; nxt = 0; stalls_seen = 0;
    for (int cyc = 0; cyc < 60 && wlog.size() < 16; cyc++) begin
      force_full = (wlog.size() == 6) && (stall > 0);
      req_data[24 +: 8] = 8'(nxt);
      #1;
      if (force_full) begin
        chk("t3_stall_ready", req_ready, 0);
        chk("t3_stall_wr", fifo_wr, 0);
        chk("t3_stall_busy", busy, 1);
        stall--;
        stalls_seen++;
      end
      if (fifo_wr) nxt++;
      tick();
    end
    force_full = 1'b0;
    chk("t3_stalls", stalls_seen, 5);
    chk("t3_count", wlog.size(), 16);
    ok = 1'b1;
    for (int i = 0; i < 16; i++) if (wlog[i] !== 8'(i)) ok = 1'b0;
    chk("t3_order", ok, 1);

    // Read priority over write, then read on empty
    req_valid = '0;
    do_reset();
    req_valid = 4'b0001; req_data[0 +: 8] = 8'h55; req_last = '0;
    tick();
    tick();
    req_data[0 +: 8] = 8'h66; req_last = 4'b0001;
    tick();
    req_data[0 +: 8] = 8'h77;
    tick();
    cons_rd = 1'b1;
    #1;
    chk("t4_ack", cons_ack, 1);
    chk("t4_ready", req_ready, 0);
    chk("t4_wr", fifo_wr, 0);
    chk("t4_rd", fifo_rd, 1);
    tick();
    cons_rd = 1'b0;
    #1;
    chk("t4_dv", cons_dv, 1);
    chk("t4_dout", dout_m, 8'h55);
    chk("t4_wr_resume", fifo_wr, 1);
    chk("t4_din_resume", fifo_din, 8'h77);
    tick();
    req_data[0 +: 8] = 8'h88; force_empty = 1'b1; cons_rd = 1'b1;
    tick();
    #1;
    chk("t4_empty_ack", cons_ack, 0);
    chk("t4_empty_ready", req_ready, 4'b0001);
    chk("t4_empty_wr", fifo_wr, 1);
    chk("t4_empty_din", fifo_din, 8'h88);
    tick();
    chk("t4_empty_dv", cons_dv, 0);
    force_empty = 1'b0; cons_rd = 1'b0; req_valid = '0; req_last = '0;

    // Reset on beat 2 of a producer-2 burst
    do_reset();
    req_valid = 4'b0100; req_data[16 +: 8] = 8'hC0;
    tick();
    #1;
    chk("t5_beat1", fifo_wr, 1);
    tick();
    req_data[16 +: 8] = 8'hC1; rst = 1'b1;
    #1;
    chk("t5_rst_wr", fifo_wr, 0);
    chk("t5_rst_ready", req_ready, 0);
    tick();
    rst = 1'b0; req_valid = 4'b1111;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_grant", grant_id, 0);
    tick();
    chk("t5_next_grant", grant_id, 0);
    chk("t5_next_busy", busy, 1);
    req_valid = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
